// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the requesters/memory side and mem_port_arbiter.
// The arbiter connects through the slave modport; the requester/memory side uses master.
interface mem_port_arbiter_if;
  logic [3:0] req;
  logic       mem_ack;
  logic [1:0] mem_sel;
  logic       mem_req;
  logic [3:0] done;
  logic       busy;
  logic       err;

  modport master (output req, mem_ack, input mem_sel, mem_req, done, busy, err);
  modport slave  (input req, mem_ack, output mem_sel, mem_req, done, busy, err);
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port among four requesters (IDLE/ACCESS/DONE).
// Optional access timeout abort is enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("TIMEOUT out of range 1..255");
  end

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] sel_q, sel_d;
  logic       mem_req_q, mem_req_d;
  logic [3:0] done_q, done_d;
  logic       busy_q, busy_d;
  logic [1:0] win, scan_idx;
  logic       win_vld;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  // Scan ptr+1 .. ptr+4; the last winner is therefore the lowest priority.
  always_comb begin
    win      = '0;
    win_vld  = 1'b0;
    scan_idx = '0;
    for (int k = 1; k <= 4; k++) begin
      scan_idx = ptr_q + 2'(k);
      if (!win_vld && bus.req[scan_idx]) begin
        win     = scan_idx;
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    mem_req_d = mem_req_q;
    done_d    = '0;
`ifdef ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          sel_d     = win;
          mem_req_d = 1'b1;
          state_d   = ACCESS;
`ifdef ARB_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end
      ACCESS: begin
        if (bus.mem_ack) begin
          mem_req_d      = 1'b0;
          done_d[sel_q]  = 1'b1;
          ptr_d          = sel_q;
          state_d        = DONE;
        end
`ifdef ARB_TIMEOUT_EN
        // An ack on the final allowed cycle takes precedence over the abort.
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          ptr_d     = sel_q;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd3;
      sel_q     <= '0;
      mem_req_q <= 1'b0;
      done_q    <= '0;
      busy_q    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      mem_req_q <= mem_req_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      err_q     <= err_d;
`endif
    end
  end

  assign bus.mem_sel = sel_q;
  assign bus.mem_req = mem_req_q;
  assign bus.done    = done_q;
  assign bus.busy    = busy_q;
`ifdef ARB_TIMEOUT_EN
  assign bus.err     = err_q;
`else
  assign bus.err     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected winners are queued when requests are
// driven and popped when the arbiter raises mem_req.
module tb_mem_port_arbiter;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic reset;
  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int ptr_m  = 3;
  int exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic int winner(input logic [3:0] r, input int p);
    for (int k = 1; k <= 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  // One access: ack_dly = ACCESS cycles until mem_ack is seen (0 = never, timeout path).
  task automatic access(input logic [3:0] r, input int ack_dly, input logic [3:0] r_after);
    int e, n;
    logic got;
    @(negedge clk);
    bus.req = r;
    bus.mem_ack = 1'b0;
    exp_q.push_back(winner(r, ptr_m));
    got = 1'b0;
    n = 0;
    while (!got && n < 5) begin
      @(negedge clk);
      n++;
      got = bus.mem_req;
    end
    chk("grant_seen", 32'(got), 32'd1);
    if (!got) return;
    chk("grant_lat", 32'(n), 32'd1);
    e = exp_q.pop_front();
    chk("grant_sel", 32'(bus.mem_sel), 32'(e));
    chk("grant_busy", 32'(bus.busy), 32'd1);
    for (int i = 1; i < ((ack_dly == 0) ? TO : ack_dly); i++) begin
      @(negedge clk);
      chk("acc_req", 32'(bus.mem_req), 32'd1);
      chk("acc_sel", 32'(bus.mem_sel), 32'(e));
      chk("acc_done", 32'(bus.done), 32'd0);
    end
    if (ack_dly != 0) bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    bus.req = r_after;
    chk("end_req", 32'(bus.mem_req), 32'd0);
    chk("end_busy", 32'(bus.busy), 32'd1);
    if (ack_dly != 0) begin
      chk("end_done", 32'(bus.done), 32'(1 << e));
      chk("end_err", 32'(bus.err), 32'd0);
    end else begin
      chk("to_done", 32'(bus.done), 32'd0);
      chk("to_err", 32'(bus.err), 32'd1);
    end
    ptr_m = e;
    @(negedge clk);
    chk("post_done", 32'(bus.done), 32'd0);
    chk("post_err", 32'(bus.err), 32'd0);
    chk("post_busy", 32'(bus.busy), 32'd0);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_sel"}, 32'(bus.mem_sel), 32'd0);
    chk({tag, "_req"}, 32'(bus.mem_req), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_err"}, 32'(bus.err), 32'd0);
  endtask

  initial begin
    int grants, last_cyc, cur, p;
    logic prev_mreq;
    reset = 1'b1;
    bus.req = '0;
    bus.mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_idle("rst");

    // Stray acks while idle with no requests must change nothing.
    bus.mem_ack = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_idle("idle_ack");
    end
    bus.mem_ack = 1'b0;

    access(4'b0001, 2, 4'b0000);

    // Saturated round robin with mem_ack tied high.
    @(negedge clk);
    p = ptr_m;
    for (int i = 0; i < 5; i++) begin
      p = winner(4'b1111, p);
      exp_q.push_back(p);
    end
    bus.req = 4'b1111;
    bus.mem_ack = 1'b1;
    grants = 0; last_cyc = 0; cur = -1; prev_mreq = 1'b0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (bus.done != 4'b0000) begin
        chk("rr_done", 32'(bus.done), 32'(1 << cur));
        if (grants == 5) begin
          bus.req = '0;
          bus.mem_ack = 1'b0;
          ptr_m = cur;
          break;
        end
      end
      if (bus.mem_req && !prev_mreq) begin
        cur = exp_q.pop_front();
        chk("rr_sel", 32'(bus.mem_sel), 32'(cur));
        if (grants > 0) chk("rr_period", 32'(cyc - last_cyc), 32'd3);
        last_cyc = cyc;
        grants++;
      end
      prev_mreq = bus.mem_req;
    end
    chk("rr_grants", 32'(grants), 32'd5);
    @(negedge clk);
    @(negedge clk);
    chk("rr_idle", 32'(bus.busy), 32'd0);

    access(4'b0100, 1, 4'b0000);
    access(4'b0101, 1, 4'b0100);
    access(4'b0100, 3, 4'b0000);
    repeat (3) access(4'b0001, 1, 4'b0000);

    // Reset in the middle of an access for requester 1.
    @(negedge clk);
    bus.req = 4'b0010;
    @(negedge clk);
    chk("rst_grant", 32'(bus.mem_sel), 32'd1);
    chk("rst_mreq", 32'(bus.mem_req), 32'd1);
    reset = 1'b1;
    bus.req = 4'b0000;
    @(negedge clk);
    reset = 1'b0;
    ptr_m = 3;
    chk("rst_acc_mreq", 32'(bus.mem_req), 32'd0);
    chk("rst_acc_busy", 32'(bus.busy), 32'd0);
    chk("rst_acc_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    chk("rst_acc_done2", 32'(bus.done), 32'd0);
    access(4'b1111, 1, 4'b0000);

`ifdef ARB_TIMEOUT_EN
    access(4'b0110, 0, 4'b0000);
    access(4'b0110, 1, 4'b0000);
    access(4'b1000, TO, 4'b0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
